// File: rtl/mult_engine_arbiter.sv
// rtl/mult_engine_arbiter.sv - round-robin arbiter sharing one start/done multiplier engine
// Bypasses zero operands and recovers a hung engine with a watchdog.
module mult_engine_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int RW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] a_in,
  input  logic [N_REQ*DW-1:0] b_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [RW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic                eng_rst,
  output logic                eng_start,
  output logic [DW-1:0]       eng_a,
  output logic [DW-1:0]       eng_b,
  input  logic                eng_done,
  input  logic [RW-1:0]       eng_result,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_RESP, S_RECOVER} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [7:0]      wdog_q, wdog_d;
  logic [DW-1:0]   eng_a_q, eng_a_d;
  logic [DW-1:0]   eng_b_q, eng_b_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            found;
  logic [PW-1:0]   win;
  logic [DW-1:0]   win_a, win_b;
  logic [N_REQ-1:0] gnt_c;
  logic            start_c, rst_c;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign win_a = a_in[int'(win)*DW +: DW];
  assign win_b = b_in[int'(win)*DW +: DW];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    wdog_d     = wdog_q;
    eng_a_d    = eng_a_q;
    eng_b_d    = eng_b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    gnt_c      = '0;
    start_c    = 1'b0;
    rst_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_c   = N_REQ'(1) << win;
          owner_d = win;
          eng_a_d = win_a;
          eng_b_d = win_b;
          ptr_d   = PW'((int'(win) + 1) % N_REQ);
          // The engine cannot normalise a zero operand, so answer directly.
          if (win_a == '0 || win_b == '0) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
            state_d    = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        start_c = 1'b1;
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wdog_d = wdog_q + 8'd1;
        if (eng_done) begin
          rsp_data_d = eng_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (wdog_q == 8'(TIMEOUT)) begin
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        rst_c      = 1'b1;
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      wdog_q     <= '0;
      eng_a_q    <= '0;
      eng_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      wdog_q     <= wdog_d;
      eng_a_q    <= eng_a_d;
      eng_b_q    <= eng_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Pulses are masked while rst is held so nothing escapes during reset.
  assign gnt       = rst ? '0 : gnt_c;
  assign eng_start = start_c & ~rst;
  assign eng_rst   = rst_c & ~rst;
  assign rsp_valid = (state_q == S_RESP && !rst) ? (N_REQ'(1) << owner_q) : '0;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_engine_arbiter.sv
// tb/tb_mult_engine_arbiter.sv - directed self-checking bench for mult_engine_arbiter
// Includes a latency-L engine model that can be told never to finish.
module tb_mult_engine_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int RW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] a_in, b_in;
  logic [N-1:0]    gnt, rsp_valid, rsp_ready;
  logic [RW-1:0]   rsp_data, eng_result;
  logic            rsp_err, eng_rst, eng_start, eng_done, busy;
  logic [DW-1:0]   eng_a, eng_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int rst_cyc = 0;
  int cnt = 0;
  int lat = 6;
  bit done_en = 1'b1;

  mult_engine_arbiter #(.N_REQ(N), .DW(DW), .RW(RW), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_rst(eng_rst), .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Engine model: done L cycles after start, result a*b.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_start) begin start_cnt <= start_cnt + 1; start_cyc <= cyc; end
    if (eng_rst) rst_cyc <= cyc;
    if (rst || eng_rst) cnt <= 0;
    else if (eng_start) cnt <= lat;
    else if (cnt > 0) cnt <= cnt - 1;
  end
  assign eng_done   = done_en && (cnt == 1);
  assign eng_result = RW'(eng_a) * RW'(eng_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp(input string tag, input int limit);
    int c;
    c = 0;
    while (rsp_valid == '0 && c < limit) begin
      tick();
      c++;
    end
    check({tag, "_rsp_seen"}, 32'(rsp_valid != '0), 32'd1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (busy && c < 400) begin
      tick();
      c++;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int order[5];
    int ng;
    int bad;
    int snap;
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; rsp_ready = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_start", 32'(eng_start), 0);
    check("rst_engrst", 32'(eng_rst), 0);
    check("rst_eng_a", 32'(eng_a), 0);
    check("rst_data", 32'(rsp_data), 0);
    check("rst_err", 32'(rsp_err), 0);
    rst = 1'b0;

    // 1: single requester, 3*5
    req = 4'b0001; a_in[7:0] = 8'd3; b_in[7:0] = 8'd5;
    #1;
    check("t1_gnt", 32'(gnt), 32'b0001);
    tick(); req = '0;
    check("t1_start", 32'(eng_start), 1);
    check("t1_eng_a", 32'(eng_a), 3);
    check("t1_eng_b", 32'(eng_b), 5);
    tick();
    check("t1_start_pulse", 32'(eng_start), 0);
    check("t1_busy", 32'(busy), 1);
    wait_rsp("t1", 50);
    check("t1_valid", 32'(rsp_valid), 32'b0001);
    check("t1_data", 32'(rsp_data), 15);
    check("t1_err", 32'(rsp_err), 0);
    rsp_ready = 4'b0001;
    tick();
    check("t1_idle", 32'(busy), 0);
    check("t1_valid_drop", 32'(rsp_valid), 0);
    rsp_ready = '0;

    // 2: all request, round-robin from ptr=0 after reset
    rst = 1'b1; tick(); rst = 1'b0;
    a_in = {8'd4, 8'd3, 8'd2, 8'd1}; b_in = {8'd2, 8'd2, 8'd2, 8'd2};
    rsp_ready = 4'hF; req = 4'hF;
    ng = 0;
    for (int c = 0; c < 300 && ng < 5; c++) begin
      #1;
      if (gnt != '0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) order[ng] = i;
        ng++;
        if (ng == 5) req = '0;
      end
      tick();
    end
    check("t2_count", 32'(ng), 5);
    check("t2_g0", 32'(order[0]), 0);
    check("t2_g1", 32'(order[1]), 1);
    check("t2_g2", 32'(order[2]), 2);
    check("t2_g3", 32'(order[3]), 3);
    check("t2_g4", 32'(order[4]), 0);
    drain();
    rsp_ready = '0;

    // 3: zero operand bypass
    snap = start_cnt;
    a_in[23:16] = 8'd0; b_in[23:16] = 8'd9; req = 4'b0100;
    #1;
    check("t3_gnt", 32'(gnt), 32'b0100);
    tick(); req = '0;
    check("t3_valid", 32'(rsp_valid), 32'b0100);
    check("t3_data", 32'(rsp_data), 0);
    check("t3_err", 32'(rsp_err), 0);
    rsp_ready = 4'b0100;
    tick(); rsp_ready = '0;
    check("t3_no_start", 32'(start_cnt), 32'(snap));

    // 4: hung engine, then normal job
    done_en = 1'b0;
    a_in[7:0] = 8'd7; b_in[7:0] = 8'd7; req = 4'b0001;
    tick(); req = '0;
    wait_rsp("t4", 400);
    check("t4_valid", 32'(rsp_valid), 32'b0001);
    check("t4_err", 32'(rsp_err), 1);
    check("t4_data", 32'(rsp_data), 0);
    check("t4_wdog_span", 32'(rst_cyc - start_cyc), 257);
    rsp_ready = 4'b0001; tick(); rsp_ready = '0;
    done_en = 1'b1;
    a_in[15:8] = 8'd4; b_in[15:8] = 8'd6; req = 4'b0010;
    #1;
    check("t4b_gnt", 32'(gnt), 32'b0010);
    tick(); req = '0;
    wait_rsp("t4b", 50);
    check("t4b_valid", 32'(rsp_valid), 32'b0010);
    check("t4b_data", 32'(rsp_data), 24);
    check("t4b_err", 32'(rsp_err), 0);
    rsp_ready = 4'b0010; tick(); rsp_ready = '0;

    // 5: response back-pressure; ptr=2 so requester 0 wins first
    a_in[7:0] = 8'd2; b_in[7:0] = 8'd3; a_in[15:8] = 8'd5; b_in[15:8] = 8'd5;
    req = 4'b0011;
    #1;
    check("t5_gnt0", 32'(gnt), 32'b0001);
    tick(); req = 4'b0010;
    wait_rsp("t5", 50);
    check("t5_valid", 32'(rsp_valid), 32'b0001);
    check("t5_data", 32'(rsp_data), 6);
    rsp_ready = 4'b0010;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid != 4'b0001 || rsp_data != 16'd6 || gnt != '0) bad++;
    end
    check("t5_stable", 32'(bad), 0);
    rsp_ready = 4'b0001;
    tick(); rsp_ready = '0;
    #1;
    check("t5_gnt1", 32'(gnt), 32'b0010);
    tick(); req = '0;
    wait_rsp("t5b", 50);
    check("t5b_data", 32'(rsp_data), 25);
    rsp_ready = 4'b0010; tick(); rsp_ready = '0;

    // 6: reset during RUN
    a_in[7:0] = 8'd9; b_in[7:0] = 8'd9; req = 4'b0001;
    tick(); req = '0;
    tick();
    check("t6_in_run", 32'(busy), 1);
    rst = 1'b1;
    tick();
    check("t6_busy", 32'(busy), 0);
    check("t6_valid", 32'(rsp_valid), 0);
    check("t6_start", 32'(eng_start), 0);
    check("t6_eng_a", 32'(eng_a), 0);
    check("t6_data", 32'(rsp_data), 0);
    rst = 1'b0;
    snap = start_cnt;
    tick(); tick();
    check("t6_no_restart", 32'(start_cnt), 32'(snap));
    req = 4'hF;
    #1;
    check("t6_gnt_ptr0", 32'(gnt), 32'b0001);
    tick(); req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
